data_sync_hs: RTL



---
 rtl/data_sync_hs_pkg.sv | 18 +
 rtl/data_sync_hs_req_bit_sync.sv | 25 ++
 rtl/data_sync_hs.sv | 83 ++++++++
 3 files changed

// File: rtl/data_sync_hs_pkg.sv
// data_sync_hs_pkg: shared state encoding and defaults for the handshake synchronizer
package data_sync_hs_pkg;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_BUS_WIDTH  = 8;

    // valid and bus_ack each live on their own state bit, so both are plain flop outputs
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        ACK  = 2'b10
    } state_t;

    function automatic logic stages_ok(input int n);
        return n >= 2;
    endfunction

endpackage

// File: rtl/data_sync_hs_req_bit_sync.sv
// req_bit_sync: multi-flop level synchronizer for the incoming request bit
module req_bit_sync
    import data_sync_hs_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] chain;

    // Shift the asynchronous level through the flop chain; the last stage is safe to use
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            chain <= '0;
        else
            chain <= {chain[NUM_STAGES-2:0], async_in};
    end

    assign sync_out = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_hs.sv
// data_sync_hs: destination-side 4-phase req/ack receiver presenting the bus as valid/ready
module data_sync_hs
    import data_sync_hs_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_req,
    output logic                 bus_ack,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 valid,
    input  logic                 ready,
    output logic                 enable_pulse,
    output logic                 proto_err
);

    if (!stages_ok(NUM_STAGES)) begin : g_bad_stages
        $error("data_sync_hs: NUM_STAGES must be at least 2");
    end

    state_t state;
    state_t state_nxt;
    logic   req_s;
    logic   capture;
    logic   err_set;

    req_bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .CLK     (CLK),
        .RST     (RST),
        .async_in(bus_req),
        .sync_out(req_s)
    );

    // Next state: capture on synced request, release on consume, rearm once request drops
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                capture   = req_s;
                state_nxt = req_s ? HOLD : IDLE;
            end
            HOLD: begin
                err_set   = ~req_s;
                state_nxt = ready ? ACK : HOLD;
            end
            ACK:     state_nxt = req_s ? ACK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture register, capture strobe and sticky early-drop flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus     <= '0;
            enable_pulse <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (capture)
                sync_bus <= unsync_bus;
            enable_pulse <= capture;
            proto_err    <= proto_err | err_set;
        end
    end

    assign valid   = state[0];
    assign bus_ack = state[1];

endmodule
